// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer around a combinational 8-bit ALU: fetches operands from a
// small register file, captures ALU results/flags, writes back, and drives an OUT port.
//
// state | meaning
// IDLE  | instr_ready high, waiting for an instruction; ALU opcode parked at 0000
// READ  | register ALU operands and opcode from latched instruction and regfile
// EXEC  | ALU settles; capture result and flags into holding registers
// WB    | writeback and flag update; OUT waits here for out_ready
module alu_exec_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_op1,
  output logic [DATA_W-1:0]  alu_op2,
  output logic [3:0]         alu_opcode,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_z,
  input  logic               alu_cy,
  input  logic               alu_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [2:0]         flags_q,
  output logic               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic [2:0]         flags_d;
  logic [DATA_W-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [3:0]         opc_q, opc_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               rz_q, rz_d, rcy_q, rcy_d, rsign_q, rsign_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [3:0]         op;
  logic [1:0]         rd, rs;
  logic               imm_sel;
  logic [DATA_W-1:0]  imm;
  logic               is_alu, is_cmp;
  logic               rsvd_unused;

  assign op          = instr_q[15:12];
  assign rd          = instr_q[11:10];
  assign imm_sel     = instr_q[9];
  assign rsvd_unused = instr_q[8];
  assign imm         = instr_q[DATA_W-1:0];
  assign rs          = instr_q[1:0];
  assign is_alu      = op[3] | op[2];
  assign is_cmp      = (op[2:0] == 3'b111);

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_opcode  = opc_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    opc_d       = opc_q;
    res_d       = res_q;
    rz_d        = rz_q;
    rcy_d       = rcy_q;
    rsign_d     = rsign_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        op1_d   = regs_q[rd];
        op2_d   = imm_sel ? imm : regs_q[rs];
        opc_d   = op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_out;
        rz_d    = alu_z;
        rcy_d   = alu_cy;
        rsign_d = alu_sign;
        if (op == 4'b0011) begin
          out_data_d  = regs_q[rd];
          out_valid_d = 1'b1;
        end
        state_d = S_WB;
      end
      default: begin
        if (is_alu) begin
          if (!is_cmp) regs_d[rd] = res_q;
          // flags_q = {sign, cy, z}; SUB with a zero result clears cy/sign
          if (op[3:2] == 2'b10) begin
            flags_d[0] = rz_q;
          end else begin
            case (op[1:0])
              2'b00:   flags_d[1]   = rcy_q;
              2'b01:   flags_d      = rz_q ? 3'b001 : {rsign_q, rcy_q, 1'b0};
              2'b10:   flags_d[0]   = rz_q;
              default: flags_d[1:0] = {rcy_q, rz_q};
            endcase
          end
        end else if (op == 4'b0001) begin
          regs_d[rd] = imm;
        end else if (op == 4'b0010) begin
          regs_d[rd] = regs_q[rs];
        end
        if (op == 4'b0011) begin
          // Writeback above is a no-op for OUT, so repeating it while stalled is harmless
          if (out_ready) begin
            out_valid_d = 1'b0;
            opc_d       = 4'b0000;
            state_d     = S_IDLE;
          end
        end else begin
          opc_d   = 4'b0000;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      flags_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      opc_q       <= '0;
      res_q       <= '0;
      rz_q        <= 1'b0;
      rcy_q       <= 1'b0;
      rsign_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      opc_q       <= opc_d;
      res_q       <= res_d;
      rz_q        <= rz_d;
      rcy_q       <= rcy_d;
      rsign_q     <= rsign_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
